// File: rtl/dmem_responder.sv
// dmem_responder
// ---------------------------------------------------------------------------
// Word-addressed data memory that answers a CPU's load/store requests.
// After reset it walks through every word writing zero (one word per cycle,
// busy high), then serves accesses. Reads are combinational. Writes commit on
// the rising edge. Misaligned, out-of-range or too-early requests are dropped
// and raise a sticky error flag. Separate counters track accepted reads and
// writes.
//
// Optional feature: define DMEM_MMIO_EN to map a 16-bit output register
// (led_out) at byte address 32'hFFFF_0000. Without it, led_out is tied to
// zero and that address is treated as out of range.
//
// Parameters
//   DEPTH_LOG2  log2 of the word count
//   BASE_ADDR   byte address of word 0
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   dmem_r     read request
//   dmem_w     write request
//   data_addr  byte address of the access
//   w_data     write data
//   dmem_data  read data (zero unless a valid read is in progress)
//   busy       high while the power-up clear runs
//   err        sticky protocol-error flag, cleared only by rst
//   rd_cnt     accepted-read counter (wraps)
//   wr_cnt     accepted-write counter (wraps)
//   led_out    memory-mapped output register
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_r,
  input  logic        dmem_w,
  input  logic [31:0] data_addr,
  input  logic [31:0] w_data,
  output logic [31:0] dmem_data,
  output logic        busy,
  output logic        err,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt,
  output logic [15:0] led_out
);

  localparam int          DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH) << 2;
  localparam logic [31:0] MMIO_ADDR = 32'hFFFF_0000;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t                state;
  logic [DEPTH_LOG2-1:0] clr_idx;
  logic [31:0]           mem [DEPTH];

  logic [31:0]           offset;
  logic [DEPTH_LOG2-1:0] index;
  logic                  aligned;
  logic                  in_range;
  logic                  mem_valid;
  logic                  mmio_valid;
  logic                  any_valid;
  logic                  any_req;

  // The offset is compared in 33 bits so a window reaching the top of the
  // address space cannot wrap around. The lower-bound check catches
  // addresses below BASE_ADDR, whose offset would otherwise wrap to a large
  // value.
  assign offset   = data_addr - BASE_ADDR;
  assign index    = offset[DEPTH_LOG2+1:2];
  assign aligned  = (data_addr[1:0] == 2'b00);
  assign in_range = (data_addr >= BASE_ADDR) && ({1'b0, offset} < MEM_BYTES);

`ifdef DMEM_MMIO_EN
  assign mmio_valid = (state == READY) && (data_addr == MMIO_ADDR);
`else
  assign mmio_valid = 1'b0;
`endif

  // If the memory window ever overlaps the MMIO address, the register wins.
  assign mem_valid = (state == READY) && aligned && in_range && !mmio_valid;
  assign any_valid = mem_valid || mmio_valid;
  assign any_req   = dmem_r || dmem_w;

  // Zero-latency read path. When read and write coincide, the write has not
  // committed yet, so the pre-write word is returned.
  always_comb begin
    dmem_data = 32'h0;
    if (dmem_r && mem_valid) begin
      dmem_data = mem[index];
    end
`ifdef DMEM_MMIO_EN
    else if (dmem_r && mmio_valid) begin
      dmem_data = {16'h0, led_out};
    end
`endif
  end

  // Memory array write port, with no reset so it can map onto RAM. The
  // power-up clear and CPU writes share the single port. These are exclusive
  // because CPU writes are only valid in READY. rst suppresses all writes, so
  // reset never zeroes the contents directly.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_idx] <= 32'h0;
      end else if (dmem_w && mem_valid) begin
        mem[index] <= w_data;
      end
    end
  end

  // Control state machine. It owns the clear sequence, the busy and sticky
  // error flags, and the access counters. busy is registered alongside
  // state, so it drops on the same edge that moves CLEAR to READY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
      busy    <= 1'b1;
      err     <= 1'b0;
      rd_cnt  <= 16'h0;
      wr_cnt  <= 16'h0;
    end else begin
      if (state == CLEAR) begin
        clr_idx <= clr_idx + DEPTH_LOG2'(1);
        if (&clr_idx) begin
          state <= READY;
          busy  <= 1'b0;
        end
      end
      if ((any_req && !any_valid) || (dmem_r && dmem_w)) begin
        err <= 1'b1;
      end
      if (dmem_r && any_valid) begin
        rd_cnt <= rd_cnt + 16'd1;
      end
      if (dmem_w && any_valid) begin
        wr_cnt <= wr_cnt + 16'd1;
      end
    end
  end

`ifdef DMEM_MMIO_EN
  // Memory-mapped output register. Only the low half of the write data is
  // kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_out <= 16'h0;
    end else if (dmem_w && mmio_valid) begin
      led_out <= w_data[15:0];
    end
  end
`else
  assign led_out = 16'h0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Directed self-checking bench for dmem_responder with a 16-word memory.
// Inputs are driven 1 time unit after each rising edge. Combinational read
// data is sampled 1 unit later. Registered outputs are sampled 1 unit after
// the edge that updates them.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        dmem_r;
  logic        dmem_w;
  logic [31:0] data_addr;
  logic [31:0] w_data;
  logic [31:0] dmem_data;
  logic        busy;
  logic        err;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;
  logic [15:0] led_out;

  int n_compared;
  int n_mismatched;

  dmem_responder #(
    .DEPTH_LOG2(4),
    .BASE_ADDR (32'h1001_0000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .dmem_r   (dmem_r),
    .dmem_w   (dmem_w),
    .data_addr(data_addr),
    .w_data   (w_data),
    .dmem_data(dmem_data),
    .busy     (busy),
    .err      (err),
    .rd_cnt   (rd_cnt),
    .wr_cnt   (wr_cnt),
    .led_out  (led_out)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dmem_r    = 1'b0;
    dmem_w    = 1'b0;
    data_addr = 32'h0;
    w_data    = 32'h0;
  endtask

  // Pulse rst for one edge.
  task automatic pulse_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Count the cycles busy stays high, bounded to 100.
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic reset_and_wait();
    int n;
    pulse_reset();
    count_busy(n);
  endtask

  // Issue a single write and let it commit.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    dmem_w    = 1'b1;
    data_addr = addr;
    w_data    = data;
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    int n;
    pulse_reset();
    n_compared++;
    if (busy !== 1'b1 || err !== 1'b0 || rd_cnt !== 16'h0 || wr_cnt !== 16'h0 ||
        led_out !== 16'h0 || dmem_data !== 32'h0) begin
      $display("[TB] FAIL reset_state: busy=%b err=%b rd=%h wr=%h led=%h data=%h, required 1 0 0 0 0 0",
               busy, err, rd_cnt, wr_cnt, led_out, dmem_data);
      n_mismatched++;
    end
    count_busy(n);
    n_compared++;
    if (n !== 16) begin
      $display("[TB] FAIL busy_len: got %0d cycles, required 16", n);
      n_mismatched++;
    end
  endtask

  task automatic test_read_zero();
    int bad;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      dmem_r    = 1'b1;
      data_addr = 32'h1001_0000 + 32'(i * 4);
      #1;
      if (dmem_data !== 32'h0) bad++;
      step();
    end
    idle_inputs();
    n_compared++;
    if (bad !== 0) begin
      $display("[TB] FAIL read_zero: %0d nonzero words, required 0", bad);
      n_mismatched++;
    end
    n_compared++;
    if (rd_cnt !== 16'd16 || err !== 1'b0) begin
      $display("[TB] FAIL read_zero_cnt: rd=%0d err=%b, required 16 0", rd_cnt, err);
      n_mismatched++;
    end
  endtask

  task automatic test_write_read();
    reset_and_wait();
    do_write(32'h1001_0008, 32'hDEAD_BEEF);
    dmem_r    = 1'b1;
    data_addr = 32'h1001_0008;
    #1;
    n_compared++;
    if (dmem_data !== 32'hDEAD_BEEF) begin
      $display("[TB] FAIL write_read_data: got %h, required deadbeef", dmem_data);
      n_mismatched++;
    end
    step();
    idle_inputs();
    n_compared++;
    if (wr_cnt !== 16'd1 || rd_cnt !== 16'd1 || err !== 1'b0) begin
      $display("[TB] FAIL write_read_cnt: wr=%0d rd=%0d err=%b, required 1 1 0", wr_cnt, rd_cnt, err);
      n_mismatched++;
    end
  endtask

  task automatic test_invalid();
    // Word 2 still holds DEADBEEF from the previous test.
    do_write(32'h1001_0002, 32'h1111_1111);
    n_compared++;
    if (err !== 1'b1) begin
      $display("[TB] FAIL misaligned_err: got %b, required 1", err);
      n_mismatched++;
    end
    do_write(32'h1000_FFFC, 32'h2222_2222);
    do_write(32'h1001_0040, 32'h3333_3333);
    dmem_r    = 1'b1;
    data_addr = 32'h1001_0000;
    #1;
    n_compared++;
    if (dmem_data !== 32'h0) begin
      $display("[TB] FAIL invalid_word0: got %h, required 0", dmem_data);
      n_mismatched++;
    end
    data_addr = 32'h1001_003C;
    #1;
    n_compared++;
    if (dmem_data !== 32'h0) begin
      $display("[TB] FAIL invalid_word15: got %h, required 0", dmem_data);
      n_mismatched++;
    end
    data_addr = 32'h1001_000A;
    #1;
    n_compared++;
    if (dmem_data !== 32'h0) begin
      $display("[TB] FAIL misaligned_read: got %h, required 0", dmem_data);
      n_mismatched++;
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) step();
    n_compared++;
    if (err !== 1'b1 || wr_cnt !== 16'd1 || rd_cnt !== 16'd1) begin
      $display("[TB] FAIL invalid_sticky: err=%b wr=%0d rd=%0d, required 1 1 1", err, wr_cnt, rd_cnt);
      n_mismatched++;
    end
  endtask

  task automatic test_both();
    reset_and_wait();
    do_write(32'h1001_0004, 32'd5);
    dmem_r    = 1'b1;
    dmem_w    = 1'b1;
    data_addr = 32'h1001_0004;
    w_data    = 32'd9;
    #1;
    n_compared++;
    if (dmem_data !== 32'd5) begin
      $display("[TB] FAIL both_old_data: got %h, required 5", dmem_data);
      n_mismatched++;
    end
    step();
    idle_inputs();
    n_compared++;
    if (err !== 1'b1 || rd_cnt !== 16'd1 || wr_cnt !== 16'd2) begin
      $display("[TB] FAIL both_flags: err=%b rd=%0d wr=%0d, required 1 1 2", err, rd_cnt, wr_cnt);
      n_mismatched++;
    end
    dmem_r    = 1'b1;
    data_addr = 32'h1001_0004;
    #1;
    n_compared++;
    if (dmem_data !== 32'd9) begin
      $display("[TB] FAIL both_new_data: got %h, required 9", dmem_data);
      n_mismatched++;
    end
    step();
    idle_inputs();
  endtask

  task automatic test_clear_restart();
    int n;
    reset_and_wait();
    do_write(32'h1001_000C, 32'hABCD_0123);
    pulse_reset();
    // Request during CLEAR, then idle until clear index 7.
    dmem_w    = 1'b1;
    data_addr = 32'h1001_0000;
    w_data    = 32'h7777_7777;
    step();
    idle_inputs();
    n_compared++;
    if (err !== 1'b1 || wr_cnt !== 16'd0) begin
      $display("[TB] FAIL clear_write: err=%b wr=%0d, required 1 0", err, wr_cnt);
      n_mismatched++;
    end
    for (int i = 0; i < 6; i++) step();
    // Reset at index 7, with a same-cycle write that must be discarded.
    rst       = 1'b1;
    dmem_w    = 1'b1;
    data_addr = 32'h1001_0004;
    w_data    = 32'h1234_5678;
    step();
    rst = 1'b0;
    idle_inputs();
    count_busy(n);
    n_compared++;
    if (n !== 16) begin
      $display("[TB] FAIL restart_busy_len: got %0d cycles, required 16", n);
      n_mismatched++;
    end
    n_compared++;
    if (err !== 1'b0 || wr_cnt !== 16'd0) begin
      $display("[TB] FAIL restart_state: err=%b wr=%0d, required 0 0", err, wr_cnt);
      n_mismatched++;
    end
    dmem_r    = 1'b1;
    data_addr = 32'h1001_000C;
    #1;
    n_compared++;
    if (dmem_data !== 32'h0) begin
      $display("[TB] FAIL restart_cleared: got %h, required 0", dmem_data);
      n_mismatched++;
    end
    data_addr = 32'h1001_0004;
    #1;
    n_compared++;
    if (dmem_data !== 32'h0) begin
      $display("[TB] FAIL restart_discard: got %h, required 0", dmem_data);
      n_mismatched++;
    end
    idle_inputs();
    step();
  endtask

  task automatic test_mmio();
    reset_and_wait();
    do_write(32'hFFFF_0000, 32'h1234_A5A5);
    dmem_r    = 1'b1;
    data_addr = 32'hFFFF_0000;
    #1;
`ifdef DMEM_MMIO_EN
    n_compared++;
    if (led_out !== 16'hA5A5 || dmem_data !== 32'h0000_A5A5 || err !== 1'b0 || wr_cnt !== 16'd1) begin
      $display("[TB] FAIL mmio: led=%h data=%h err=%b wr=%0d, required a5a5 0000a5a5 0 1",
               led_out, dmem_data, err, wr_cnt);
      n_mismatched++;
    end
`else
    n_compared++;
    if (led_out !== 16'h0 || dmem_data !== 32'h0 || err !== 1'b1 || wr_cnt !== 16'd0) begin
      $display("[TB] FAIL mmio_off: led=%h data=%h err=%b wr=%0d, required 0 0 1 0",
               led_out, dmem_data, err, wr_cnt);
      n_mismatched++;
    end
`endif
    step();
    idle_inputs();
  endtask

  task automatic test_idle();
    logic [15:0] rd_before;
    logic [15:0] wr_before;
    reset_and_wait();
    do_write(32'h1001_0010, 32'h0BAD_F00D);
    rd_before = rd_cnt;
    wr_before = wr_cnt;
    for (int i = 0; i < 5; i++) step();
    n_compared++;
    if (rd_cnt !== rd_before || wr_cnt !== wr_before || err !== 1'b0 || busy !== 1'b0) begin
      $display("[TB] FAIL idle: rd=%0d wr=%0d err=%b busy=%b, required %0d %0d 0 0",
               rd_cnt, wr_cnt, err, busy, rd_before, wr_before);
      n_mismatched++;
    end
    dmem_r    = 1'b1;
    data_addr = 32'h1001_0010;
    #1;
    n_compared++;
    if (dmem_data !== 32'h0BAD_F00D) begin
      $display("[TB] FAIL idle_hold: got %h, required 0badf00d", dmem_data);
      n_mismatched++;
    end
    step();
    idle_inputs();
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst          = 1'b0;
    idle_inputs();
    #2;
    test_reset();
    test_read_zero();
    test_write_read();
    test_invalid();
    test_both();
    test_clear_restart();
    test_mmio();
    test_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
